// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM encoding,
// status register bit positions and default register addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_FULL = 0;
  localparam int STAT_IDLE = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [31:0] DEF_ADDR_DATA = 32'hFFFF_FFFE;
  localparam logic [31:0] DEF_ADDR_STAT = 32'hFFFF_FFFD;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter. DEPTH == 1 collapses to a single
// holding register; larger depths use a power-of-2 ring with an occupancy count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] data,
  output logic       full,
  output logic       empty
);

  if (DEPTH == 1) begin : g_hold
    logic [7:0] hold;
    logic       valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid <= 1'b0;
      end else if (push) begin
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (push) hold <= din;
    end

    assign data  = hold;
    assign full  = valid;
    assign empty = !valid;
  end else begin : g_ring
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // A push into a full ring with a simultaneous pop overwrites the head
    // slot only after the shifter has captured it on the same edge.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
    end

    assign data  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO and status register.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise one holding register.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 66000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [31:0] ADDR_DATA  = DEF_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT  = DEF_ADDR_STAT,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  we,
  input  logic [2:0]  re,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        uart_tx,
  output logic        busy
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
`ifdef UART_TX_FIFO_EN
  localparam int unsigned FIFO_N = FIFO_DEPTH;
`else
  localparam int unsigned FIFO_N = 1;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic             wr_data, rd_stat, push, pop, ovf_set, tick, ovf;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_data, shreg;
  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             tx_p1, frame_p1;
  logic [31:0]      status;
  logic             unused_din;

  assign unused_din = ^din[31:8];
  assign wr_data    = (we != 2'b00) && (addr == ADDR_DATA);
  assign rd_stat    = (re != 3'b000) && (addr == ADDR_STAT);
  assign tick       = (cnt == '0);
  assign push       = wr_data && (!fifo_full || pop);
  assign ovf_set    = wr_data && fifo_full && !pop;

  uart_tx_fifo #(.DEPTH(FIFO_N)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din[7:0]),
    .pop   (pop),
    .data  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: if (tick) state_nxt = DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_nxt = START;
            pop       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      cnt     <= CNT_RELOAD;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (tick) begin
        cnt <= CNT_RELOAD;
        if (state == DATA) bit_idx <= bit_idx + 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) shreg <= fifo_data;
  end

  // Stage p1: line driver registered one cycle behind the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_p1    <= 1'b1;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= (state != IDLE);
      case (state)
        START:   tx_p1 <= 1'b0;
        DATA:    tx_p1 <= shreg[bit_idx];
        default: tx_p1 <= 1'b1;
      endcase
    end
  end

  always_comb begin
    status            = '0;
    status[STAT_FULL] = fifo_full;
    status[STAT_IDLE] = fifo_empty && (state == IDLE);
    status[STAT_OVF]  = ovf;
  end

  // A dropped write on the same edge as a status read keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      dout <= '0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (rd_stat) ovf <= 1'b0;
      dout <= rd_stat ? status : '0;
    end
  end

  assign uart_tx = tx_p1;
  assign busy    = (state != IDLE) || !fifo_empty || frame_p1;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line monitor decodes 8N1 frames and
// checks them against a queue of bytes expected from the writes issued.
module tb_uart_tx_mmio;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] A_DATA   = 32'hFFFF_FFFE;
  localparam logic [31:0] A_STAT   = 32'hFFFF_FFFD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  we = 2'b00;
  logic [2:0]  re = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        uart_tx;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_mmio #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .ADDR_DATA  (A_DATA),
    .ADDR_STAT  (A_STAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    we = 2'b01; addr = a; din = {24'hABCDEF, d};
    @(posedge clk); #1;
    we = 2'b00;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    re = 3'b010; addr = a;
    @(posedge clk); #1;
    re = 3'b000;
    v = dout;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_within_budget", 32'(n < limit), 32'd1);
  endtask

  // Line monitor: samples both ends of every bit period (10 clocks)
  initial begin
    int mcnt;
    logic mact;
    logic mbit;
    logic [7:0] mbyte;
    mact = 1'b0; mcnt = 0; mbit = 1'b1; mbyte = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (uart_tx === 1'b0) begin
          mact = 1'b1; mcnt = 0; mbit = 1'b0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt % 10 == 0) begin
          mbit = uart_tx;
          if (mcnt <= 80) mbyte = {uart_tx, mbyte[7:1]};
          if (mcnt == 90) chk("stop_bit", 32'(uart_tx), 32'd1);
        end else if (mcnt % 10 == 9) begin
          chk("bit_hold", 32'(uart_tx), 32'(mbit));
        end
        if (mcnt == 99) begin
          mact = 1'b0;
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("frame_byte", 32'(mbyte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    int c0, lows, bhi;

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", dout, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Status and decode of other addresses
    rd(A_STAT, v);
    chk("stat_idle", v, 32'h2);
    @(posedge clk); #1;
    chk("dout_no_access", dout, 32'h0);
    rd(A_DATA, v);
    chk("rd_data_addr", v, 32'h0);
    rd(32'h0000_1000, v);
    chk("rd_other_addr", v, 32'h0);
    we = 2'b11; addr = A_STAT; din = 32'h77;
    @(posedge clk); #1;
    we = 2'b00;
    chk("wr_other_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("wr_other_tx", 32'(uart_tx), 32'd1);

    // Single byte 0x55: latency, bit timing, busy release
    starts.delete();
    exp_q.push_back(8'h55);
    wr(A_DATA, 8'h55);
    c0 = cyc;
    chk("a_busy_on_write", 32'(busy), 32'd1);
    chk("a_tx_e0", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    chk("a_tx_e1", 32'(uart_tx), 32'd1);
    @(posedge clk); #1;
    chk("a_tx_e2", 32'(uart_tx), 32'd0);
    wait_idle(300);
    chk("a_busy_fall_cycle", 32'(cyc - c0), 32'd102);
    chk("a_one_frame", 32'(starts.size()), 32'd1);
    rd(A_STAT, v);
    chk("a_stat_after", v, 32'h2);

`ifdef UART_TX_FIFO_EN
    // Five back-to-back writes fill the FIFO behind the first frame
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h41 + i));
      wr(A_DATA, 8'(8'h41 + i));
    end
    wait_idle(800);
    chk("b_frames", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++) chk("b_gap", 32'(starts[i] - starts[i-1]), 32'd100);
    rd(A_STAT, v);
    chk("b_stat_no_ovf", v, 32'h2);

    // Six writes: last one dropped, overflow sticky until read
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h41 + i));
      wr(A_DATA, 8'(8'h41 + i));
    end
    rd(A_STAT, v);
    chk("c_stat_ovf", v, 32'h5);
    rd(A_STAT, v);
    chk("c_stat_cleared", v, 32'h1);
    wait_idle(800);
    chk("c_frames", 32'(starts.size()), 32'd5);
    rd(A_STAT, v);
    chk("c_stat_after", v, 32'h2);
`else
    // Holding register: second write lands on the pop edge, third is dropped
    starts.delete();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    wr(A_DATA, 8'h41);
    wr(A_DATA, 8'h42);
    rd(A_STAT, v);
    chk("h_stat_full", v, 32'h1);
    wr(A_DATA, 8'h43);
    rd(A_STAT, v);
    chk("h_stat_ovf", v, 32'h5);
    rd(A_STAT, v);
    chk("h_stat_cleared", v, 32'h1);
    wait_idle(500);
    chk("h_frames", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) chk("h_gap", 32'(starts[1] - starts[0]), 32'd100);
    rd(A_STAT, v);
    chk("h_stat_after", v, 32'h2);
`endif

    // Reset during data bit 1 of 0xA5 with bytes queued behind it
    wr(A_DATA, 8'hA5);
    c0 = cyc;
    wr(A_DATA, 8'h11);
`ifdef UART_TX_FIFO_EN
    wr(A_DATA, 8'h22);
`endif
    while (cyc < c0 + 25) begin
      @(posedge clk); #1;
    end
    #2;
    chk("d_pre_rst_low", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("d_rst_tx", 32'(uart_tx), 32'd1);
    chk("d_rst_busy", 32'(busy), 32'd0);
    chk("d_rst_dout", dout, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    rd(A_STAT, v);
    chk("d_stat_after_rst", v, 32'h2);
    lows = 0; bhi = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) lows++;
      if (busy !== 1'b0) bhi++;
    end
    chk("d_no_frames_tx", 32'(lows), 32'd0);
    chk("d_no_frames_busy", 32'(bhi), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
